// File: rtl/hdk_monitor_mc.sv
// Multi-channel req/ack handshake monitor: flags early, late and spurious acks per channel.
// Optional concurrent assertions/covers compiled when HDK_MON_SVA_EN is defined.
module hdk_monitor_mc #(
  parameter int NCH     = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NCH-1:0]                       req,
  input  logic [NCH-1:0]                       ack,
  input  logic                                 clr,
  output logic [NCH-1:0]                       hdk_err,
  output logic [NCH-1:0]                       err_pulse,
  output logic                                 err_any,
  output logic [CNT_W-1:0]                     err_cnt,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_err_ch,
  output logic [1:0]                           first_err_type
);

  localparam int FW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = $clog2(NCH + 1);
  localparam int SW = CNT_W + PW + 1;

  localparam logic [7:0] MIN_L = 8'(MIN_LAT);
  localparam logic [7:0] MAX_L = 8'(MAX_LAT);

  localparam logic [1:0] ET_NONE    = 2'b00;
  localparam logic [1:0] ET_TIMEOUT = 2'b01;
  localparam logic [1:0] ET_EARLY   = 2'b10;
  localparam logic [1:0] ET_SPUR    = 2'b11;

  if (NCH < 1 || MIN_LAT < 1 || MAX_LAT < MIN_LAT || MAX_LAT > 255) begin : g_bad_param
    $fatal(1, "hdk_monitor_mc: illegal parameters NCH=%0d MIN_LAT=%0d MAX_LAT=%0d",
           NCH, MIN_LAT, MAX_LAT);
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [PW-1:0] popcount(input logic [NCH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [SW-1:0] s;
    logic [SW-1:0] lim;
    s   = SW'(a) + SW'(b);
    lim = SW'({CNT_W{1'b1}});
    if (s > lim) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  state_t     state_p0 [NCH];
  logic [7:0] lat_p0   [NCH];
  state_t     state_nx [NCH];
  logic [7:0] lat_nx   [NCH];
  logic [1:0] etype    [NCH];
  logic [NCH-1:0] new_err;
  logic [PW-1:0]  new_cnt;
  logic [FW-1:0]  cand_ch;
  logic [1:0]     cand_type;

  // Stage 0: per-channel handshake FSMs and error classification
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nx[i] = state_p0[i];
      lat_nx[i]   = lat_p0[i];
      etype[i]    = ET_NONE;
      case (state_p0[i])
        IDLE: begin
          if (ack[i]) begin
            etype[i] = ET_SPUR;
          end else if (req[i]) begin
            state_nx[i] = WAIT;
            lat_nx[i]   = 8'd1;
          end
        end
        WAIT: begin
          if (ack[i]) begin
            if (lat_p0[i] < MIN_L) begin
              etype[i]    = ET_EARLY;
              state_nx[i] = IDLE;
            end else if (req[i]) begin
              lat_nx[i] = 8'd1;
            end else begin
              state_nx[i] = IDLE;
            end
          end else if (lat_p0[i] >= MAX_L) begin
            etype[i]    = ET_TIMEOUT;
            state_nx[i] = IDLE;
          end else begin
            lat_nx[i] = lat_p0[i] + 8'd1;
          end
        end
        default: begin
          state_nx[i] = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    new_err   = '0;
    cand_ch   = '0;
    cand_type = ET_NONE;
    for (int i = 0; i < NCH; i++) begin
      new_err[i] = |etype[i];
    end
    // Scan downward so the lowest erroring channel wins
    for (int i = NCH - 1; i >= 0; i--) begin
      if (new_err[i]) begin
        cand_ch   = FW'(i);
        cand_type = etype[i];
      end
    end
    new_cnt = popcount(new_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_p0[i] <= IDLE;
        lat_p0[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_p0[i] <= state_nx[i];
        lat_p0[i]   <= lat_nx[i];
      end
    end
  end

  // Stage 1: registered error reporting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hdk_err        <= '0;
      err_pulse      <= '0;
      err_cnt        <= '0;
      first_err_ch   <= '0;
      first_err_type <= ET_NONE;
    end else if (clr) begin
      // Errors seen on the clearing edge start the new record
      hdk_err        <= new_err;
      err_pulse      <= new_err;
      err_cnt        <= sat_add('0, new_cnt);
      first_err_ch   <= cand_ch;
      first_err_type <= cand_type;
    end else begin
      hdk_err   <= hdk_err | new_err;
      err_pulse <= new_err;
      err_cnt   <= sat_add(err_cnt, new_cnt);
      if (first_err_type == ET_NONE && |new_err) begin
        first_err_ch   <= cand_ch;
        first_err_type <= cand_type;
      end
    end
  end

  assign err_any = |hdk_err;

`ifdef HDK_MON_SVA_EN
  for (genvar g = 0; g < NCH; g++) begin : g_sva
    logic pass_now;
    assign pass_now = (state_p0[g] == WAIT) && ack[g] &&
                      (lat_p0[g] >= MIN_L) && (lat_p0[g] <= MAX_L);

    a_resp_window: assert property (@(posedge clk) disable iff (!reset_n)
      (state_p0[g] == IDLE && req[g] && !ack[g]) |-> ##[MIN_LAT:MAX_LAT] ack[g])
      else $error("%m: ch %0d ack missing from latency window, ack=%b", g, $sampled(ack[g]));

    a_no_stray_ack: assert property (@(posedge clk) disable iff (!reset_n)
      ack[g] |-> (state_p0[g] == WAIT))
      else $error("%m: ch %0d ack outside WAIT, ack=%b", g, $sampled(ack[g]));

    a_err_sticky: assert property (@(posedge clk) disable iff (!reset_n)
      $fell(hdk_err[g]) |-> $past(clr))
      else $error("%m: ch %0d hdk_err fell without clr, ack=%b", g, $sampled(ack[g]));

    c_timeout: cover property (@(posedge clk) disable iff (!reset_n) etype[g] == ET_TIMEOUT);
    c_early:   cover property (@(posedge clk) disable iff (!reset_n) etype[g] == ET_EARLY);
    c_spur:    cover property (@(posedge clk) disable iff (!reset_n) etype[g] == ET_SPUR);
    c_b2b:     cover property (@(posedge clk) disable iff (!reset_n)
      (pass_now && req[g]) ##1 pass_now);
  end
`endif

endmodule

// File: tb/tb_hdk_monitor_mc.sv
// Directed bench for hdk_monitor_mc: three instances cover default, MIN_LAT=2/CNT_W=2 and MIN=MAX=1.
module tb_hdk_monitor_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [3:0] req_d, ack_d, req_m, ack_m, req_1, ack_1;
  logic       clr_d, clr_m, clr_1;

  logic [3:0] hdk_d, pulse_d, hdk_m, pulse_m, hdk_1, pulse_1;
  logic       any_d, any_m, any_1;
  logic [7:0] cnt_d, cnt_1;
  logic [1:0] cnt_m;
  logic [1:0] fch_d, fch_m, fch_1;
  logic [1:0] ftype_d, ftype_m, ftype_1;

  int pass_cnt = 0;
  int total    = 0;

  hdk_monitor_mc u_def (
    .clk(clk), .reset_n(reset_n), .req(req_d), .ack(ack_d), .clr(clr_d),
    .hdk_err(hdk_d), .err_pulse(pulse_d), .err_any(any_d), .err_cnt(cnt_d),
    .first_err_ch(fch_d), .first_err_type(ftype_d)
  );

  hdk_monitor_mc #(.NCH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(2)) u_m2 (
    .clk(clk), .reset_n(reset_n), .req(req_m), .ack(ack_m), .clr(clr_m),
    .hdk_err(hdk_m), .err_pulse(pulse_m), .err_any(any_m), .err_cnt(cnt_m),
    .first_err_ch(fch_m), .first_err_type(ftype_m)
  );

  hdk_monitor_mc #(.NCH(4), .MIN_LAT(1), .MAX_LAT(1), .CNT_W(8)) u_m1 (
    .clk(clk), .reset_n(reset_n), .req(req_1), .ack(ack_1), .clr(clr_1),
    .hdk_err(hdk_1), .err_pulse(pulse_1), .err_any(any_1), .err_cnt(cnt_1),
    .first_err_ch(fch_1), .first_err_type(ftype_1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req_d = '0; ack_d = '0; clr_d = 1'b0;
    req_m = '0; ack_m = '0; clr_m = 1'b0;
    req_1 = '0; ack_1 = '0; clr_1 = 1'b0;
    step; step;
    check("rst_d_err",   32'(hdk_d), 0);
    check("rst_d_pulse", 32'(pulse_d), 0);
    check("rst_d_cnt",   32'(cnt_d), 0);
    check("rst_d_any",   32'(any_d), 0);
    check("rst_d_fch",   32'(fch_d), 0);
    check("rst_d_ftype", 32'(ftype_d), 0);
    check("rst_m2_cnt",  32'(cnt_m), 0);
    check("rst_m1_err",  32'(hdk_1), 0);
    reset_n = 1'b1;

    // Pass on ch0: req at edge 1, ack at edge 3
    req_d = 4'b0001; step;
    req_d = 4'b0000; step;
    ack_d = 4'b0001; step;
    ack_d = 4'b0000;
    check("t1_err",   32'(hdk_d), 0);
    check("t1_pulse", 32'(pulse_d), 0);
    check("t1_cnt",   32'(cnt_d), 0);
    check("t1_idle",  32'(int'(u_def.state_p0[0])), 0);

    // Timeout on ch2 at edge 5
    req_d = 4'b0100; step;
    req_d = 4'b0000; step; step; step;
    check("t2_pre_pulse", 32'(pulse_d), 0);
    step;
    check("t2_pulse", 32'(pulse_d), 32'b0100);
    check("t2_err",   32'(hdk_d), 32'b0100);
    check("t2_any",   32'(any_d), 1);
    check("t2_cnt",   32'(cnt_d), 1);
    check("t2_fch",   32'(fch_d), 2);
    check("t2_ftype", 32'(ftype_d), 1);
    step;
    check("t2_pulse_gone", 32'(pulse_d), 0);
    check("t2_sticky",     32'(hdk_d), 32'b0100);

    // clr coincident with a ch1 timeout, then clr alone
    req_d = 4'b0010; step;
    req_d = 4'b0000; step; step; step;
    clr_d = 1'b1; step;
    clr_d = 1'b0;
    check("t5_err",   32'(hdk_d), 32'b0010);
    check("t5_pulse", 32'(pulse_d), 32'b0010);
    check("t5_cnt",   32'(cnt_d), 1);
    check("t5_fch",   32'(fch_d), 1);
    check("t5_ftype", 32'(ftype_d), 1);
    clr_d = 1'b1; step;
    clr_d = 1'b0;
    check("t5c_err",   32'(hdk_d), 0);
    check("t5c_any",   32'(any_d), 0);
    check("t5c_cnt",   32'(cnt_d), 0);
    check("t5c_fch",   32'(fch_d), 0);
    check("t5c_ftype", 32'(ftype_d), 0);
    check("t5c_pulse", 32'(pulse_d), 0);

    // MIN_LAT=2: early ack ch1 at edge 2, spurious ack ch3 at edge 4
    req_m = 4'b0010; step;
    req_m = 4'b0000; ack_m = 4'b0010; step;
    ack_m = 4'b0000;
    check("t3_pulse", 32'(pulse_m), 32'b0010);
    check("t3_cnt",   32'(cnt_m), 1);
    check("t3_fch",   32'(fch_m), 1);
    check("t3_ftype", 32'(ftype_m), 2);
    step;
    ack_m = 4'b1000; step;
    ack_m = 4'b0000;
    check("t3s_pulse", 32'(pulse_m), 32'b1000);
    check("t3s_err",   32'(hdk_m), 32'b1010);
    check("t3s_cnt",   32'(cnt_m), 2);
    check("t3s_fch",   32'(fch_m), 1);
    check("t3s_ftype", 32'(ftype_m), 2);

    // CNT_W=2 saturation with simultaneous spurious acks on ch0 and ch3
    clr_m = 1'b1; step;
    clr_m = 1'b0;
    check("t4_clr_cnt", 32'(cnt_m), 0);
    ack_m = 4'b0001; step;
    ack_m = 4'b0000; step;
    ack_m = 4'b0001; step;
    check("t4_cnt2",  32'(cnt_m), 2);
    check("t4_fch",   32'(fch_m), 0);
    check("t4_ftype", 32'(ftype_m), 3);
    ack_m = 4'b1001; step;
    ack_m = 4'b0000;
    check("t4_sat_cnt",   32'(cnt_m), 3);
    check("t4_sat_pulse", 32'(pulse_m), 32'b1001);
    check("t4_sat_err",   32'(hdk_m), 32'b1001);
    check("t4_sat_fch",   32'(fch_m), 0);
    step;
    check("t4_pulse_gone", 32'(pulse_m), 0);
    ack_m = 4'b1001; step;
    ack_m = 4'b0000;
    check("t4_hold_cnt",   32'(cnt_m), 3);
    check("t4_hold_pulse", 32'(pulse_m), 32'b1001);

    // MIN=MAX=1: back-to-back transactions, then reset mid-WAIT
    req_1 = 4'b0001; step;
    ack_1 = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step;
      check("t6_b2b_pulse", 32'(pulse_1), 0);
    end
    check("t6_err",  32'(hdk_1), 0);
    check("t6_cnt",  32'(cnt_1), 0);
    check("t6_wait", 32'(int'(u_m1.state_p0[0])), 1);
    reset_n = 1'b0;
    req_1 = 4'b0000; ack_1 = 4'b0000;
    step;
    check("t6r_m1_idle", 32'(int'(u_m1.state_p0[0])), 0);
    check("t6r_m1_err",  32'(hdk_1), 0);
    check("t6r_m2_err",  32'(hdk_m), 0);
    check("t6r_m2_any",  32'(any_m), 0);
    check("t6r_m2_cnt",  32'(cnt_m), 0);
    check("t6r_m2_fch",  32'(fch_m), 0);
    check("t6r_m2_ftype", 32'(ftype_m), 0);
    check("t6r_m2_pulse", 32'(pulse_m), 0);
    reset_n = 1'b1;
    step; step;
    check("t6r_no_timeout", 32'(hdk_1), 0);
    ack_1 = 4'b0001; step;
    ack_1 = 4'b0000;
    check("t6r_spur_pulse", 32'(pulse_1), 32'b0001);
    check("t6r_spur_ftype", 32'(ftype_1), 3);
    check("t6r_spur_cnt",   32'(cnt_1), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
